// File: rtl/floppy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | floppy_pkg : shared geometry (SPT, sector offsets) and FSM state encoding |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
package floppy_pkg;

    localparam int unsigned DS_THRESHOLD = 409600;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_REQ   = 3'd2,
        ST_XFER  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    // Mac GCR zones: 16 tracks each of 12/11/10/9 sectors, then 8 sectors.
    function automatic logic [3:0] spt_of(input logic [6:0] track);
        logic [3:0] spt;
        case (track[6:4])
            3'd0:    spt = 4'd12;
            3'd1:    spt = 4'd11;
            3'd2:    spt = 4'd10;
            3'd3:    spt = 4'd9;
            default: spt = 4'd8;
        endcase
        return spt;
    endfunction

    function automatic logic [10:0] soff_of(input logic [6:0] track);
        logic [10:0] t;
        logic [10:0] soff;
        t = {4'b0000, track};
        case (track[6:4])
            3'd0:    soff = t * 11'd12;
            3'd1:    soff = 11'd192 + (t - 11'd16) * 11'd11;
            3'd2:    soff = 11'd368 + (t - 11'd32) * 11'd10;
            3'd3:    soff = 11'd528 + (t - 11'd48) * 11'd9;
            default: soff = 11'd672 + (t - 11'd64) * 11'd8;
        endcase
        return soff;
    endfunction

endpackage
`default_nettype wire

// File: rtl/floppy_track_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | floppy_track_ram : one-track byte buffer, IWM write port + SD read port  |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module floppy_track_ram #(
    parameter int DEPTH = 6144,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [7:0]    i_a_data,
    input  logic          i_b_en,
    input  logic [AW-1:0] i_b_addr,
    output logic [7:0]    o_b_dout
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] b_dout_q;

    always_ff @(posedge clk) begin
        if (i_a_we) begin
            mem_q[i_a_addr] <= i_a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_dout_q <= 8'h00;
        end else if (i_b_en) begin
            b_dout_q <= mem_q[i_b_addr];
        end
    end

    assign o_b_dout = b_dout_q;

endmodule
`default_nettype wire

// File: rtl/floppy_track_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | floppy_track_writer : buffers one IWM-written track, flushes dirty       |
// |                       sectors to the disk image as 512-byte SD writes    |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module floppy_track_writer #(
    parameter int          MAX_SPT      = 12,
    parameter int unsigned DS_THRESHOLD = floppy_pkg::DS_THRESHOLD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        drive,
    input  logic        side,
    input  logic [6:0]  track,
    input  logic [31:0] img_size0,
    input  logic [31:0] img_size1,
    input  logic        wr_en,
    input  logic [13:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        flush,
    output logic        dirty,
    output logic [10:0] sd_lba,
    output logic [1:0]  sd_wr,
    input  logic        sd_busy,
    input  logic [8:0]  sd_addr,
    output logic [7:0]  sd_dout
);

    import floppy_pkg::*;

    localparam int c_sec_w = $clog2(MAX_SPT);
    localparam int c_aw    = c_sec_w + 9;

    state_t               state_q, state_d;
    logic [MAX_SPT-1:0]   dirty_vec_q, dirty_vec_d;
    logic [8:0]           tag_q, tag_d;
    logic [3:0]           spt_q, spt_d;
    logic [10:0]          base_q, base_d;
    logic [c_sec_w-1:0]   sec_q, sec_d;
    logic [10:0]          sd_lba_q, sd_lba_d;
    logic [1:0]           sd_wr_q, sd_wr_d;
    logic                 pend_q, pend_d;
    logic                 eject_q, eject_d;

    logic [8:0]           w_cur_tag;
    logic [31:0]          w_cur_size;
    logic [31:0]          w_tag_size;
    logic [3:0]           w_cur_spt;
    logic [10:0]          w_cur_soff;
    logic [10:0]          w_cur_base;
    logic [3:0]           w_lim_spt;
    logic                 w_any_dirty;
    logic                 w_wr_ready;
    logic                 w_accept;
    logic                 w_store;
    logic                 w_ejected;
    logic                 w_rd_en;
    logic                 w_found;
    logic [c_sec_w-1:0]   w_first;

    always_comb begin
        w_cur_tag   = {drive, side, track};
        w_cur_size  = drive ? img_size1 : img_size0;
        w_tag_size  = tag_q[8] ? img_size1 : img_size0;
        w_cur_spt   = spt_of(track);
        w_cur_soff  = soff_of(track);
        // Double-sided images interleave sides per track: side 1 follows side 0.
        if (w_cur_size > DS_THRESHOLD) begin
            w_cur_base = (w_cur_soff << 1) + (side ? {7'b0, w_cur_spt} : 11'd0);
        end else begin
            w_cur_base = w_cur_soff;
        end
        w_any_dirty = |dirty_vec_q;
        w_wr_ready  = (state_q == ST_IDLE) && !(w_any_dirty && (w_cur_tag != tag_q));
        w_accept    = wr_en && w_wr_ready;
        w_lim_spt   = w_any_dirty ? spt_q : w_cur_spt;
        w_store     = w_accept && (w_cur_size != 32'd0)
                      && (wr_addr[13:9] < {1'b0, w_lim_spt})
                      && (32'(wr_addr[13:9]) < MAX_SPT);
        w_ejected   = w_any_dirty && (w_tag_size == 32'd0);

        w_first = '0;
        w_found = 1'b0;
        for (int i = MAX_SPT - 1; i >= 0; i--) begin
            if (dirty_vec_q[i]) begin
                w_first = i[c_sec_w-1:0];
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        dirty_vec_d = dirty_vec_q;
        tag_d       = tag_q;
        spt_d       = spt_q;
        base_d      = base_q;
        sec_d       = sec_q;
        sd_lba_d    = sd_lba_q;
        sd_wr_d     = sd_wr_q;
        pend_d      = pend_q;
        eject_d     = eject_q;
        w_rd_en     = 1'b0;

        if (w_accept && !w_any_dirty && (w_cur_size != 32'd0)) begin
            tag_d  = w_cur_tag;
            spt_d  = w_cur_spt;
            base_d = w_cur_base;
        end
        if (w_store) begin
            dirty_vec_d[wr_addr[c_sec_w+8:9]] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                eject_d = 1'b0;
                if (w_ejected) begin
                    dirty_vec_d = '0;
                    pend_d      = 1'b0;
                end else if (w_accept) begin
                    // Defer a coincident flush so this byte is part of it.
                    pend_d = pend_q | flush;
                end else begin
                    pend_d = 1'b0;
                    if (w_any_dirty && (flush || pend_q || (w_cur_tag != tag_q))) begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (w_ejected) begin
                    dirty_vec_d = '0;
                    state_d     = ST_IDLE;
                end else if (!w_found) begin
                    state_d = ST_IDLE;
                end else begin
                    sec_d    = w_first;
                    sd_lba_d = base_q + {{(11 - c_sec_w){1'b0}}, w_first};
                    sd_wr_d  = tag_q[8] ? 2'b10 : 2'b01;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_ejected) begin
                    eject_d = 1'b1;
                end
                if (sd_busy) begin
                    sd_wr_d = 2'b00;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                w_rd_en = 1'b1;
                if (!sd_busy) begin
                    if (eject_q || w_ejected) begin
                        dirty_vec_d = '0;
                        eject_d     = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end else if (w_ejected) begin
                    eject_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                dirty_vec_d[sec_q] = 1'b0;
                state_d            = ST_SCAN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dirty_vec_q <= '0;
            tag_q       <= 9'h1ff;
            spt_q       <= 4'd0;
            base_q      <= 11'd0;
            sec_q       <= '0;
            sd_lba_q    <= 11'd0;
            sd_wr_q     <= 2'b00;
            pend_q      <= 1'b0;
            eject_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dirty_vec_q <= dirty_vec_d;
            tag_q       <= tag_d;
            spt_q       <= spt_d;
            base_q      <= base_d;
            sec_q       <= sec_d;
            sd_lba_q    <= sd_lba_d;
            sd_wr_q     <= sd_wr_d;
            pend_q      <= pend_d;
            eject_q     <= eject_d;
        end
    end

    floppy_track_ram #(
        .DEPTH (MAX_SPT * 512),
        .AW    (c_aw)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_a_we   (w_store),
        .i_a_addr ({wr_addr[c_sec_w+8:9], wr_addr[8:0]}),
        .i_a_data (wr_data),
        .i_b_en   (w_rd_en),
        .i_b_addr ({sec_q, sd_addr}),
        .o_b_dout (sd_dout)
    );

    // Reset must cut an in-flight SD request without waiting for the clock edge.
    assign sd_wr    = sd_wr_q & {2{~rst}};
    assign wr_ready = w_wr_ready & ~rst;
    assign dirty    = w_any_dirty & ~rst;
    assign sd_lba   = sd_lba_q;

endmodule
`default_nettype wire

// File: tb/tb_floppy_track_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_floppy_track_writer : directed self-checking bench for the writer     |
// | Revision               : 1.0                                             |
// +--------------------------------------------------------------------------+
module tb_floppy_track_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        drive;
    logic        side;
    logic [6:0]  track;
    logic [31:0] img_size0;
    logic [31:0] img_size1;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        flush;
    logic        dirty;
    logic [10:0] sd_lba;
    logic [1:0]  sd_wr;
    logic        sd_busy;
    logic [8:0]  sd_addr;
    logic [7:0]  sd_dout;

    int checks  = 0;
    int errors  = 0;
    int req_cnt = 0;
    logic [1:0] last_wr = 2'b00;
    int r0;

    logic [7:0] mdl    [12][512];
    bit         mvalid [12][512];

    floppy_track_writer dut (
        .clk       (clk),
        .rst       (rst),
        .drive     (drive),
        .side      (side),
        .track     (track),
        .img_size0 (img_size0),
        .img_size1 (img_size1),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .flush     (flush),
        .dirty     (dirty),
        .sd_lba    (sd_lba),
        .sd_wr     (sd_wr),
        .sd_busy   (sd_busy),
        .sd_addr   (sd_addr),
        .sd_dout   (sd_dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sd_wr != 2'b00 && last_wr == 2'b00) req_cnt <= req_cnt + 1;
        last_wr <= sd_wr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        foreach (mvalid[i, j]) mvalid[i][j] = 1'b0;
    endtask

    task automatic wr(input int sec, input int byt, input logic [7:0] d, input bit keep);
        wr_en   = 1'b1;
        wr_addr = 14'(sec * 512 + byt);
        wr_data = d;
        if (keep) begin
            mdl[sec][byt]    = d;
            mvalid[sec][byt] = 1'b1;
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Plays the SD controller for one sector write.
    task automatic serve(input string tag, input logic [1:0] ew, input logic [10:0] elba,
                         input int sec, input int eject_at);
        int n = 0;
        while (sd_wr == 2'b00 && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_req_timeout"}, (n < 50) ? 32'd1 : 32'd0, 32'd1);
        chk({tag, "_sd_wr"}, 32'(sd_wr), 32'(ew));
        chk({tag, "_sd_lba"}, 32'(sd_lba), 32'(elba));
        sd_busy = 1'b1;
        step();
        chk({tag, "_sd_wr_drop"}, 32'(sd_wr), 32'd0);
        chk({tag, "_wr_ready_busy"}, 32'(wr_ready), 32'd0);
        for (int i = 0; i < 512; i++) begin
            sd_addr = 9'(i);
            if (i == eject_at) img_size0 = 32'd0;
            step();
            if (mvalid[sec][i]) chk({tag, "_sd_dout"}, 32'(sd_dout), 32'(mdl[sec][i]));
        end
        sd_busy = 1'b0;
        sd_addr = 9'd0;
        step();
    endtask

    initial begin
        rst = 1'b1; drive = 1'b0; side = 1'b0; track = 7'd0;
        img_size0 = 32'd819200; img_size1 = 32'd409600;
        wr_en = 1'b0; wr_addr = 14'd0; wr_data = 8'd0;
        flush = 1'b0; sd_busy = 1'b0; sd_addr = 9'd0;
        clear_model();
        step(); step(); step();
        chk("rst_sd_wr", 32'(sd_wr), 32'd0);
        chk("rst_sd_lba", 32'(sd_lba), 32'd0);
        chk("rst_sd_dout", 32'(sd_dout), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_dirty", 32'(dirty), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

        // Double-sided, drive 0, side 1, track 20, sector 3: lba 486.
        clear_model();
        side = 1'b1; track = 7'd20;
        step();
        r0 = req_cnt;
        wr(3, 0, 8'hA5, 1'b1);
        wr(3, 1, 8'h3C, 1'b1);
        wr(3, 255, 8'h77, 1'b1);
        wr(3, 511, 8'hE1, 1'b1);
        chk("t1_dirty_set", 32'(dirty), 32'd1);
        pulse_flush();
        serve("t1", 2'b01, 11'd486, 3, -1);
        step(); step(); step();
        chk("t1_dirty_clear", 32'(dirty), 32'd0);
        chk("t1_req_count", 32'(req_cnt - r0), 32'd1);

        // Single-sided, drive 1, track 0, sectors 7/0/5, then a track change.
        clear_model();
        drive = 1'b1; side = 1'b0; track = 7'd0;
        step();
        r0 = req_cnt;
        wr(7, 0, 8'h11, 1'b1);
        wr(0, 0, 8'h22, 1'b1);
        wr(0, 511, 8'h23, 1'b1);
        wr(5, 10, 8'h33, 1'b1);
        chk("t2_dirty_set", 32'(dirty), 32'd1);
        track = 7'd1;
        #1;
        chk("t2_wr_ready_low", 32'(wr_ready), 32'd0);
        serve("t2a", 2'b10, 11'd0, 0, -1);
        serve("t2b", 2'b10, 11'd5, 5, -1);
        serve("t2c", 2'b10, 11'd7, 7, -1);
        step(); step(); step();
        chk("t2_wr_ready_high", 32'(wr_ready), 32'd1);
        chk("t2_dirty_clear", 32'(dirty), 32'd0);
        chk("t2_req_count", 32'(req_cnt - r0), 32'd3);

        // Track 70 has 8 sectors: sector 9 is discarded.
        clear_model();
        drive = 1'b0; side = 1'b0; track = 7'd70;
        step();
        r0 = req_cnt;
        wr(9, 0, 8'hAB, 1'b0);
        chk("t3_dirty_none", 32'(dirty), 32'd0);
        pulse_flush();
        step(); step(); step(); step();
        chk("t3_req_count", 32'(req_cnt - r0), 32'd0);

        // Eject during the first of two sectors (track 5, side 0: base 120).
        clear_model();
        track = 7'd5;
        step();
        r0 = req_cnt;
        wr(1, 4, 8'h5C, 1'b1);
        wr(2, 4, 8'hC5, 1'b1);
        pulse_flush();
        serve("t4", 2'b01, 11'd121, 1, 100);
        for (int k = 0; k < 8; k++) step();
        chk("t4_dirty_clear", 32'(dirty), 32'd0);
        chk("t4_req_count", 32'(req_cnt - r0), 32'd1);
        img_size0 = 32'd819200;
        step();

        // Reset while a request is pending.
        clear_model();
        wr(4, 0, 8'h99, 1'b1);
        pulse_flush();
        begin
            int n = 0;
            while (sd_wr == 2'b00 && n < 50) begin
                step();
                n++;
            end
            chk("t5_req_timeout", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        end
        rst = 1'b1;
        #1;
        chk("t5_sd_wr_rst", 32'(sd_wr), 32'd0);
        step();
        chk("t5_dirty_rst", 32'(dirty), 32'd0);
        rst = 1'b0;
        step();
        r0 = req_cnt;
        pulse_flush();
        step(); step(); step(); step();
        chk("t5_flush_noop", 32'(req_cnt - r0), 32'd0);
        chk("t5_dirty_after", 32'(dirty), 32'd0);

        // Write and flush in the same cycle: drive 1, track 2, single-sided, lba 24+6.
        clear_model();
        drive = 1'b1; side = 1'b0; track = 7'd2;
        step();
        r0 = req_cnt;
        wr_en = 1'b1; wr_addr = 14'(6 * 512 + 3); wr_data = 8'h5A; flush = 1'b1;
        mdl[6][3] = 8'h5A; mvalid[6][3] = 1'b1;
        #1;
        chk("t6_wr_ready", 32'(wr_ready), 32'd1);
        step();
        wr_en = 1'b0; flush = 1'b0;
        serve("t6", 2'b10, 11'd30, 6, -1);
        step(); step(); step();
        chk("t6_dirty_clear", 32'(dirty), 32'd0);
        chk("t6_req_count", 32'(req_cnt - r0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
